fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter register in the RV32I core. It takes the current fetch address, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small FIFO for the decode stage. It tells the PC when a fetch was accepted, and flushes all in-flight and buffered work on a taken branch or jump.

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, the PC register, instruction memory and decode.
// Handshakes: a memory request transfers when imem_req && imem_gnt in the same cycle (req may drop
// without a grant); a queue entry transfers to decode when inst_valid && inst_ready.
interface fetch_stage_if;
  logic [31:0] pc_in;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fetch_stall;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, fetch_stall, inst_valid, inst_out, inst_pc
  );

  modport slave (
    output pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, fetch_stall, inst_valid, inst_out, inst_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: one outstanding word request, responses buffered with their PCs
// in a DEPTH-entry queue for decode; a redirect flushes the queue and any request in flight.
module fetch_stage #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus,
  output logic [1:0]    dbg_state_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic          pop, push, accept, in_wait;
  logic [RW-1:0] reserve;
  logic [31:0]   aligned_pc;
  logic          unused_pc_low;

  assign aligned_pc    = {bus.pc_in[31:2], 2'b00};
  assign unused_pc_low = ^bus.pc_in[1:0];

  assign in_wait = (state_q == S_WAIT);
  assign pop     = (count_q != '0) && bus.inst_ready;
  // Slots already promised: buffered entries plus the one response still on its way.
  assign reserve = {1'b0, count_q} + RW'(in_wait) - RW'(pop);

  assign bus.imem_req  = rst && !bus.redirect && (reserve < RW'(DEPTH)) &&
                         ((state_q == S_IDLE) || (in_wait && bus.imem_rvalid));
  assign bus.imem_addr = aligned_pc;
  assign accept        = bus.imem_req && bus.imem_gnt;
  assign bus.fetch_stall = !accept;
  assign push          = in_wait && bus.imem_rvalid && !bus.redirect;

  assign bus.inst_valid = (count_q != '0);
  assign bus.inst_out   = inst_mem_q[head_q];
  assign bus.inst_pc    = pc_mem_q[head_q];
  assign dbg_state_o    = state_q;

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    if (accept) req_pc_d = aligned_pc;
    if (bus.redirect) begin
      case (state_q)
        S_WAIT:  state_d = bus.imem_rvalid ? S_IDLE : S_DROP;
        S_DROP:  state_d = bus.imem_rvalid ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE:  state_d = accept ? S_WAIT : S_IDLE;
        S_WAIT:  if (bus.imem_rvalid) state_d = accept ? S_WAIT : S_IDLE;
        S_DROP:  if (bus.imem_rvalid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[tail_q] <= bus.imem_rdata;
      pc_mem_q[tail_q]   <= req_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random memory latency, grants,
// backpressure and redirects checked against a transaction-level model of the stage.
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus();
  logic [1:0] unused_dbg_state;

  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (unused_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic redir, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    bus.pc_in       = pc;
    bus.redirect    = redir;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.inst_ready  = rdy;
    #1;
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'h00100093 + (32'(i) << 20);
  endfunction

  logic        pending, flushed, in_wait, pop, exp_req;
  logic        rv, redir, gnt, rdy;
  logic [31:0] pc, data, pend_pc;
  logic [63:0] head;
  int          wait_cnt, reserve;

  initial begin
    // Reset with garbage on every input
    rst = 1'b0;
    drive(32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1);
    check_bit("rst_req", bus.imem_req, 1'b0);
    check_bit("rst_valid", bus.inst_valid, 1'b0);
    check("rst_inst_out", bus.inst_out, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check_bit("rst_stall", bus.fetch_stall, 1'b1);
    cyc();
    check_bit("rst_req_hold", bus.imem_req, 1'b0);

    // Release: first cycle requests pc 0
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check_bit("rel_req", bus.imem_req, 1'b1);
    check("rel_addr", bus.imem_addr, 32'h0);
    check_bit("rel_stall", bus.fetch_stall, 1'b0);
    cyc();
    drive(32'h4, 1'b0, 1'b0, 1'b1, 32'hAAAA0000, 1'b1);
    check_bit("rel_req_on_rvalid", bus.imem_req, 1'b1);
    check_bit("rel_stall_no_gnt", bus.fetch_stall, 1'b1);
    check_bit("rel_no_write_through", bus.inst_valid, 1'b0);
    cyc();
    drive(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_bit("rel_valid", bus.inst_valid, 1'b1);
    check("rel_out", bus.inst_out, 32'hAAAA0000);
    check("rel_pc", bus.inst_pc, 32'h0);
    cyc();
    drive(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_bit("rel_drained", bus.inst_valid, 1'b0);

    // Single fetch with latency 3
    drive(32'h13, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check_bit("lat3_req", bus.imem_req, 1'b1);
    check("lat3_addr", bus.imem_addr, 32'h10);
    cyc();
    for (int k = 1; k <= 2; k++) begin
      drive(32'h14, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      check_bit("lat3_req_wait", bus.imem_req, 1'b0);
      check_bit("lat3_stall_wait", bus.fetch_stall, 1'b1);
      check_bit("lat3_valid_wait", bus.inst_valid, 1'b0);
      cyc();
    end
    drive(32'h14, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b1);
    check_bit("lat3_valid_rsp", bus.inst_valid, 1'b0);
    cyc();
    drive(32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_bit("lat3_valid", bus.inst_valid, 1'b1);
    check("lat3_out", bus.inst_out, 32'h00500093);
    check("lat3_pc", bus.inst_pc, 32'h10);
    cyc();
    drive(32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_bit("lat3_drained", bus.inst_valid, 1'b0);

    // Streaming at latency 1 with decode always ready
    drive(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check_bit("stream_req0", bus.imem_req, 1'b1);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      drive((i < 4) ? 32'(4 * i) : 32'h0, 1'b0, (i < 4), 1'b1, word_of(i - 1), 1'b1);
      if (i < 4) begin
        check_bit("stream_stall", bus.fetch_stall, 1'b0);
        check("stream_addr", bus.imem_addr, 32'(4 * i));
      end
      if (i >= 2) begin
        check_bit("stream_valid", bus.inst_valid, 1'b1);
        check("stream_out", bus.inst_out, word_of(i - 2));
        check("stream_pc", bus.inst_pc, 32'(4 * (i - 2)));
      end
      cyc();
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("stream_out_last", bus.inst_out, word_of(3));
    check("stream_pc_last", bus.inst_pc, 32'hC);
    cyc();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_bit("stream_drained", bus.inst_valid, 1'b0);

    // Backpressure fills both entries
    drive(32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check_bit("bp_req0", bus.imem_req, 1'b1);
    cyc();
    drive(32'h44, 1'b0, 1'b1, 1'b1, word_of(40), 1'b0);
    check_bit("bp_req1", bus.imem_req, 1'b1);
    cyc();
    drive(32'h48, 1'b0, 1'b1, 1'b1, word_of(41), 1'b0);
    check_bit("bp_req_full_rsp", bus.imem_req, 1'b0);
    check_bit("bp_stall_full_rsp", bus.fetch_stall, 1'b1);
    cyc();
    drive(32'h48, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check_bit("bp_req_full", bus.imem_req, 1'b0);
    check_bit("bp_stall_full", bus.fetch_stall, 1'b1);
    cyc();
    drive(32'h48, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check_bit("bp_req_on_pop", bus.imem_req, 1'b1);
    check_bit("bp_stall_on_pop", bus.fetch_stall, 1'b0);
    check("bp_head0", bus.inst_pc, 32'h40);
    cyc();
    drive(32'h4C, 1'b0, 1'b0, 1'b1, word_of(42), 1'b0);
    check("bp_head1", bus.inst_pc, 32'h44);
    check_bit("bp_req_refull", bus.imem_req, 1'b0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(32'h4C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("bp_drain_pc", bus.inst_pc, 32'(32'h44 + 4 * i));
      check("bp_drain_out", bus.inst_out, word_of(41 + i));
      cyc();
    end
    drive(32'h4C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_bit("bp_drained", bus.inst_valid, 1'b0);

    // Redirect while waiting: response dropped
    drive(32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check_bit("rw_req", bus.imem_req, 1'b1);
    cyc();
    drive(32'h20, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check_bit("rw_req_redirect", bus.imem_req, 1'b0);
    cyc();
    drive(32'h100, 1'b0, 1'b1, 1'b1, 32'hBADBAD00, 1'b1);
    check_bit("rw_req_drop", bus.imem_req, 1'b0);
    check_bit("rw_stall_drop", bus.fetch_stall, 1'b1);
    cyc();
    drive(32'h100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check_bit("rw_valid_after_drop", bus.inst_valid, 1'b0);
    check_bit("rw_req_new", bus.imem_req, 1'b1);
    check("rw_addr_new", bus.imem_addr, 32'h100);
    cyc();
    drive(32'h104, 1'b0, 1'b0, 1'b1, word_of(7), 1'b1);
    cyc();
    drive(32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rw_new_pc", bus.inst_pc, 32'h100);
    check("rw_new_out", bus.inst_out, word_of(7));
    cyc();

    // Redirect coincident with rvalid and pop, one entry buffered
    drive(32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc();
    drive(32'h204, 1'b0, 1'b1, 1'b1, word_of(9), 1'b0);
    check_bit("rc_req_stream", bus.imem_req, 1'b1);
    cyc();
    drive(32'h204, 1'b1, 1'b1, 1'b1, word_of(10), 1'b1);
    check_bit("rc_valid_before", bus.inst_valid, 1'b1);
    check_bit("rc_req_redirect", bus.imem_req, 1'b0);
    cyc();
    drive(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_bit("rc_empty", bus.inst_valid, 1'b0);
    check_bit("rc_req_next", bus.imem_req, 1'b1);
    cyc();

    // Random traffic against a transaction-level model
    pending = 1'b0;
    flushed = 1'b0;
    pend_pc = '0;
    wait_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 2000; c++) begin
      if (pending) begin
        wait_cnt--;
        rv = (wait_cnt == 0);
      end else begin
        rv = ($urandom_range(0, 7) == 0);
      end
      redir = ($urandom_range(0, 9) == 0);
      gnt   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      pc    = $urandom;
      data  = $urandom;
      drive(pc, redir, gnt, rv, data, rdy);

      in_wait = pending && !flushed;
      pop     = (exp_q.size() != 0) && rdy;
      reserve = exp_q.size() + (in_wait ? 1 : 0) - (pop ? 1 : 0);
      exp_req = !redir && (reserve < DEPTH) && (!pending || (in_wait && rv));

      check_bit("rnd_req", bus.imem_req, exp_req);
      check_bit("rnd_stall", bus.fetch_stall, !(exp_req && gnt));
      check_bit("rnd_valid", bus.inst_valid, exp_q.size() != 0);
      if (exp_req) check("rnd_addr", bus.imem_addr, {pc[31:2], 2'b00});
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("rnd_out", bus.inst_out, head[63:32]);
        check("rnd_pc", bus.inst_pc, head[31:0]);
      end

      if (redir) begin
        exp_q.delete();
        if (pending) begin
          if (rv) pending = 1'b0;
          else    flushed = 1'b1;
        end
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (pending && rv) begin
          if (!flushed) exp_q.push_back({data, pend_pc});
          pending = 1'b0;
        end
      end
      if (exp_req && gnt) begin
        pending  = 1'b1;
        flushed  = 1'b0;
        pend_pc  = {pc[31:2], 2'b00};
        wait_cnt = $urandom_range(1, 4);
      end
      cyc();
    end

    // Asynchronous reset in the middle of traffic
    rst = 1'b0;
    drive(32'h500, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0);
    check_bit("arst_req", bus.imem_req, 1'b0);
    check_bit("arst_valid", bus.inst_valid, 1'b0);
    check_bit("arst_stall", bus.fetch_stall, 1'b1);
    check("arst_out", bus.inst_out, 32'h0);
    check("arst_pc", bus.inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
